// File: rtl/apb_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_pkg
//  Description : Shared types and default widths for the APB-to-memory slave.
//                Holds the FSM state encoding and the default address, data
//                and wait-count widths.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int WAIT_W_DEF = 4;

    // The encodings are visible on the debug state port, so they are fixed.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        WAIT   = 3'd2,
        ACCESS = 3'd3
    } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_wait_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : apb_wait_ctr
//  Description : Loadable down-counter that paces the WAIT state.
//  Ports       : clk, rst_n     clock, asynchronous active-low reset
//                load, load_val load the count (takes priority over dec)
//                dec            decrement by one, saturating at zero
//                is_zero        count == 0
//                is_one         count == 1
//  Revision    : 1.0  initial release
// ============================================================================
module apb_wait_ctr #(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              is_zero,
    output logic              is_one
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_zero = (count_q == '0);
    assign is_one  = (count_q == WAIT_W'(1));

endmodule
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_slave
//  Description : APB slave bridging one APB segment to a single-port memory
//                bus. Inserts a programmable number of wait states and issues
//                exactly one memory strobe per completed transfer.
//  Ports       : clk, rst_n             clock, asynchronous active-low reset
//                sel/enable/write/addr/wdata   APB request
//                wait_cycles             wait states, sampled at setup
//                id                      instance ID, latched at setup
//                ready/rdata             APB response (registered)
//                state                   FSM state for debug
//                mem_*                   memory-side address, data, strobes
//                slverr                  APB error (APB_SLVERR_EN only)
//  Config      : APB_SLVERR_EN  adds slverr; flags enable seen in IDLE and
//                addresses in the upper half of the map; no strobe on error.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WAIT_W = WAIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              enable,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [WAIT_W-1:0] wait_cycles,
    input  logic [1:0]        id,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic [2:0]        state,
`ifdef APB_SLVERR_EN
    output logic              slverr,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic [1:0]        mem_id
);

    apb_state_t        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        id_q, id_d;
    logic              ready_q, ready_d;
    logic              wren_q, wren_d;
    logic              rden_q, rden_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic latch;
    logic go_access;
    logic err;
    logic wait_zero;
    logic wait_one;

    apb_wait_ctr #(
        .WAIT_W   (WAIT_W)
    ) u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (latch),
        .load_val (wait_cycles),
        .dec      (state_q == WAIT),
        .is_zero  (wait_zero),
        .is_one   (wait_one)
    );

    // Next state. 'latch' marks the setup phase being accepted.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel && !enable) begin
                    state_d = SETUP;
                    latch   = 1'b1;
                end
            end
            SETUP: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (enable) begin
                    state_d = wait_zero ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                // Leaving on count==1 gives exactly N clocks in WAIT.
                if (!sel) begin
                    state_d = IDLE;
                end else if (wait_one) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (sel && !enable) begin
                    state_d = SETUP;
                    latch   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef APB_SLVERR_EN
    logic proto_err_q, proto_err_d;
    logic slverr_q, slverr_d;

    // Sticky flag: enable seen with no setup is reported on the next
    // transfer, then cleared once that transfer completes.
    always_comb begin
        proto_err_d = proto_err_q;
        if (state_q == ACCESS) begin
            proto_err_d = 1'b0;
        end
        if ((state_q == IDLE) && enable) begin
            proto_err_d = 1'b1;
        end
    end

    // addr >= 2**(ADDR_W-1) is exactly the address MSB being set.
    assign err      = proto_err_q | addr_q[ADDR_W-1];
    assign slverr_d = go_access && err;
    assign slverr   = slverr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_q <= 1'b0;
            slverr_q    <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
            slverr_q    <= slverr_d;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Response flops load on entry to ACCESS so they are valid exactly
    // during the single ACCESS clock.
    always_comb begin
        go_access = (state_d == ACCESS);
        write_d   = latch ? write : write_q;
        addr_d    = latch ? addr  : addr_q;
        wdata_d   = latch ? wdata : wdata_q;
        id_d      = latch ? id    : id_q;
        ready_d   = go_access;
        wren_d    = go_access && !err &&  write_q;
        rden_d    = go_access && !err && !write_q;
        rdata_d   = rden_d ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= '0;
            ready_q <= 1'b0;
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            ready_q <= ready_d;
            wren_q  <= wren_d;
            rden_q  <= rden_d;
            rdata_q <= rdata_d;
        end
    end

    assign state     = state_q;
    assign ready     = ready_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wren  = wren_q;
    assign mem_rden  = rden_q;
    assign mem_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_mem_slave
//  Description : Directed self-checking bench for apb_mem_slave. The memory
//                returns 32'hA5A5_0000 | mem_addr combinationally.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_mem_slave;

`ifdef APB_SLVERR_EN
    localparam bit C_SLVERR = 1'b1;
`else
    localparam bit C_SLVERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        enable = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wait_cycles = '0;
    logic [1:0]  id = '0;
    logic        ready;
    logic [31:0] rdata;
    logic [2:0]  state;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_wren;
    logic        mem_rden;
    logic [1:0]  mem_id;
`ifdef APB_SLVERR_EN
    logic        slverr;
`endif

    always #5 clk = ~clk;

    assign mem_rdata = 32'hA5A5_0000 | {24'h0, mem_addr};

    apb_mem_slave #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .WAIT_W      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (sel),
        .enable      (enable),
        .write       (write),
        .addr        (addr),
        .wdata       (wdata),
        .wait_cycles (wait_cycles),
        .id          (id),
        .ready       (ready),
        .rdata       (rdata),
        .state       (state),
`ifdef APB_SLVERR_EN
        .slverr      (slverr),
`endif
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_wren    (mem_wren),
        .mem_rden    (mem_rden),
        .mem_id      (mem_id)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wren_cnt = 0;
    int          rden_cnt = 0;
    int          bad_cnt  = 0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe bookkeeping: pulses counted, plus any strobe outside a ready
    // clock or both strobes together.
    always @(negedge clk) begin
        if (mem_wren) wren_cnt++;
        if (mem_rden) rden_cnt++;
        if ((mem_wren && mem_rden) || ((mem_wren || mem_rden) && !ready)) bad_cnt++;
    end

    // One APB transfer. Clock k=1 is the first enable clock (slave in
    // SETUP); the registered ready answers at k = wait + 2.
    task automatic apb_xfer(input string tag, input bit wr, input logic [7:0] a,
                            input logic [31:0] wd, input logic [3:0] nw, input bit exp_err);
        int w0;
        int r0;
        int got_at;
        w0 = wren_cnt;
        r0 = rden_cnt;
        got_at = 0;
        @(posedge clk); #1;
        sel = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = wd;
        wait_cycles = nw; id = a[1:0];
        @(posedge clk); #1;
        enable = 1'b1;
        wait_cycles = ~nw;
        for (int k = 1; k <= 40 && got_at == 0; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, "_setup_state"}, {29'h0, state}, 32'd1);
            if (ready) begin
                got_at = k;
                check({tag, "_access_state"}, {29'h0, state}, 32'd3);
                check({tag, "_wren"}, {31'h0, mem_wren}, {31'h0, wr & ~exp_err});
                check({tag, "_rden"}, {31'h0, mem_rden}, {31'h0, ~wr & ~exp_err});
`ifdef APB_SLVERR_EN
                check({tag, "_slverr"}, {31'h0, slverr}, {31'h0, exp_err});
`endif
            end
            @(posedge clk); #1;
        end
        sel = 1'b0; enable = 1'b0;
        check({tag, "_ready_clk"}, got_at, {28'h0, nw} + 32'd2);
        @(negedge clk);
        check({tag, "_end_state"}, {29'h0, state}, 32'd0);
        check({tag, "_ready_low"}, {31'h0, ready}, 32'd0);
        check({tag, "_mem_addr"}, {24'h0, mem_addr}, {24'h0, a});
        check({tag, "_mem_id"}, {30'h0, mem_id}, {30'h0, a[1:0]});
        if (wr) check({tag, "_mem_wdata"}, mem_wdata, wd);
        if (!wr && !exp_err) last_rdata = 32'hA5A5_0000 | {24'h0, a};
        check({tag, "_rdata"}, rdata, last_rdata);
        @(posedge clk); #1;
        check({tag, "_wren_pulses"}, wren_cnt - w0, (wr && !exp_err) ? 32'd1 : 32'd0);
        check({tag, "_rden_pulses"}, rden_cnt - r0, (!wr && !exp_err) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int w0;
        int r0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {29'h0, state}, 32'd0);
        check("rst_ready", {31'h0, ready}, 32'd0);
        check("rst_wren", {31'h0, mem_wren}, 32'd0);
        check("rst_rden", {31'h0, mem_rden}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", {24'h0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_id", {30'h0, mem_id}, 32'd0);
        rst_n = 1'b1;

        // Main function, zero and non-zero wait states
        apb_xfer("wr_w0", 1'b1, 8'h03, 32'h1234_5678, 4'd0, 1'b0);
        apb_xfer("rd_w0", 1'b0, 8'h01, 32'h0, 4'd0, 1'b0);
        apb_xfer("wr_w5", 1'b1, 8'h42, 32'hDEAD_BEEF, 4'd5, 1'b0);
        apb_xfer("rd_w1", 1'b0, 8'h22, 32'h0, 4'd1, 1'b0);
        apb_xfer("rd_w3", 1'b0, 8'h35, 32'h0, 4'd3, 1'b0);
        apb_xfer("wr_w15", 1'b1, 8'h7F, 32'hCAFE_F00D, 4'd15, 1'b0);

        // Reset asserted while in WAIT
        w0 = wren_cnt;
        r0 = rden_cnt;
        @(posedge clk); #1;
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 8'h66;
        wdata = 32'h0BAD_0BAD; wait_cycles = 4'd3; id = 2'd2;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstw_in_wait", {29'h0, state}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_state", {29'h0, state}, 32'd0);
        check("rstw_ready", {31'h0, ready}, 32'd0);
        check("rstw_mem_addr", {24'h0, mem_addr}, 32'd0);
        check("rstw_mem_id", {30'h0, mem_id}, 32'd0);
        @(posedge clk); #1;
        sel = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rstw_no_strobe", (wren_cnt - w0) + (rden_cnt - r0), 32'd0);
        last_rdata = '0;
        apb_xfer("wr_after_rst", 1'b1, 8'h05, 32'h5555_AAAA, 4'd0, 1'b0);

        // Enable with no setup phase is ignored by the FSM
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        check("stray_en_state0", {29'h0, state}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("stray_en_state1", {29'h0, state}, 32'd0);
        check("stray_en_ready", {31'h0, ready}, 32'd0);
        @(posedge clk); #1;
        enable = 1'b0;
        apb_xfer("rd_after_stray", 1'b0, 8'h10, 32'h0, 4'd0, C_SLVERR);

        // Upper half of the address map
        apb_xfer("wr_hi_addr", 1'b1, 8'h80, 32'hFFFF_0000, 4'd2, C_SLVERR);
        apb_xfer("rd_hi_addr", 1'b0, 8'hC4, 32'h0, 4'd1, C_SLVERR);

        check("strobe_discipline", bad_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
